// File: rtl/series_sequencer_if.sv
// Control bundle between the series sequencer and its MAC datapath / consumer.
// The master side is the sequencer; the slave side drives start and out_ack.
interface series_sequencer_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic             out_ack;
    logic             input_en;
    logic             load_in;
    logic             clr_acc;
    logic             sel_old_or_new;
    logic             mul_en;
    logic             sum_en;
    logic [CNT_W-1:0] term_idx;
    logic             busy;
    logic             done;

    modport master (
        input  start, out_ack,
        output input_en, load_in, clr_acc, sel_old_or_new,
               mul_en, sum_en, term_idx, busy, done
    );

    modport slave (
        output start, out_ack,
        input  input_en, load_in, clr_acc, sel_old_or_new,
               mul_en, sum_en, term_idx, busy, done
    );
endinterface

// File: rtl/series_sequencer.sv
// Moore FSM sequencing N_TERMS multiply/accumulate steps of a series datapath:
// LOAD, then N_TERMS MUL/ACC pairs, then DONE held until acknowledged.
module series_sequencer #(
    parameter int N_TERMS = 4,
    parameter int CNT_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    series_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        ACC,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic input_en, load_in, clr_acc, sel_old_or_new;
    logic mul_en, sum_en, busy, done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        input_en       = 1'b0;
        load_in        = 1'b0;
        clr_acc        = 1'b0;
        sel_old_or_new = 1'b0;
        mul_en         = 1'b0;
        sum_en         = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        case (state_q)
            IDLE: begin
                input_en = 1'b1;
                busy     = 1'b0;
                cnt_d    = '0;
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                load_in = 1'b1;
                clr_acc = 1'b1;
                cnt_d   = '0;
                state_d = MUL;
            end
            MUL: begin
                mul_en = 1'b1;
                // First term multiplies the fresh operand; later terms reuse the previous product.
                sel_old_or_new = (cnt_q == '0);
                state_d        = ACC;
            end
            ACC: begin
                sum_en = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = MUL;
                end
            end
            DONE: begin
                done = 1'b1;
                // term_idx holds the last index while the result waits for its consumer.
                if (bus.out_ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.input_en       = input_en;
    assign bus.load_in        = load_in;
    assign bus.clr_acc        = clr_acc;
    assign bus.sel_old_or_new = sel_old_or_new;
    assign bus.mul_en         = mul_en;
    assign bus.sum_en         = sum_en;
    assign bus.term_idx       = cnt_q;
    assign bus.busy           = busy;
    assign bus.done           = done;
endmodule
